// File: rtl/sw_frame_arb_mux.sv
// sw_frame_arb_mux: N-to-1 AXI-Stream frame multiplexer with round-robin, non-interleaving arbitration.
// Define SW_ARB_OVERSIZE_TRUNC_EN to cut frames longer than MAX_BEATS beats (m_tuser marks the cut).
module sw_frame_arb_mux #(
  parameter int PORTS     = 4,
  parameter int DATA_W    = 64,
  parameter int DEST_W    = 2,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 32,
  localparam int KEEP_W   = DATA_W / 8
) (
  input  logic                    SysClk,
  input  logic                    Rst,
  input  logic [PORTS*DATA_W-1:0] s_tdata,
  input  logic [PORTS*KEEP_W-1:0] s_tkeep,
  input  logic [PORTS-1:0]        s_tvalid,
  input  logic [PORTS-1:0]        s_tlast,
  output logic [PORTS-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic [KEEP_W-1:0]       m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [DEST_W-1:0]       m_tdest,
  output logic                    m_tuser,
  input  logic                    m_tready,
  output logic [PORTS*CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]        trunc_cnt,
  output logic [PORTS-1:0]        grant_oh
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_e;

  if (PORTS < 2 || PORTS > 16 || DEST_W < IDX_W || MAX_BEATS < 1) begin : g_param_check
    $error("sw_frame_arb_mux: illegal parameter set");
  end

  state_e             state_q, state_d;
  logic [PORTS-1:0]   grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  m_tdata_q, m_tdata_d;
  logic [KEEP_W-1:0]  m_tkeep_q, m_tkeep_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;
  logic [DEST_W-1:0]  m_tdest_q, m_tdest_d;
  logic [CNT_W-1:0]   frame_cnt_q [PORTS];
  logic [CNT_W-1:0]   frame_cnt_d [PORTS];

`ifdef SW_ARB_OVERSIZE_TRUNC_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic               m_tuser_q, m_tuser_d;
  logic [CNT_W-1:0]   trunc_cnt_q, trunc_cnt_d;
`endif

  logic               out_free;
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic [KEEP_W-1:0]  sel_keep;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free  = ~m_tvalid_q | m_tready;
  assign sel_valid = s_tvalid[gidx_q];
  assign sel_last  = s_tlast[gidx_q];
  assign sel_data  = s_tdata[gidx_q*DATA_W +: DATA_W];
  assign sel_keep  = s_tkeep[gidx_q*KEEP_W +: KEEP_W];

  function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr_q, wrapping PORTS-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(PORTS)) cand = cand - (IDX_W+1)'(PORTS);
      if (!win_found && s_tvalid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_oh_d  = grant_oh_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tlast_d   = m_tlast_q;
    m_tdest_d   = m_tdest_q;
    m_tvalid_d  = m_tvalid_q & ~m_tready;
    frame_cnt_d = frame_cnt_q;
    s_tready    = '0;
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
    beat_cnt_d  = beat_cnt_q;
    m_tuser_d   = m_tuser_q;
    trunc_cnt_d = trunc_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_PASS;
          gidx_d     = win_idx;
          grant_oh_d = PORTS'(1) << win_idx;
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
          beat_cnt_d = '0;
`endif
        end
      end

      ST_PASS: begin
        s_tready = grant_oh_q & {PORTS{out_free}};
        if (sel_valid && out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = sel_data;
          m_tkeep_d  = sel_keep;
          m_tlast_d  = sel_last;
          m_tdest_d  = DEST_W'(gidx_q);
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
          m_tuser_d  = 1'b0;
`endif
          if (sel_last) begin
            if (frame_cnt_q[gidx_q] != '1) frame_cnt_d[gidx_q] = frame_cnt_q[gidx_q] + CNT_W'(1);
            rr_ptr_d   = next_port(gidx_q);
            grant_oh_d = '0;
            state_d    = ST_IDLE;
          end
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
          else if (beat_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
            // The cut frame is counted once here; its dropped tail does not count again.
            m_tlast_d = 1'b1;
            m_tuser_d = 1'b1;
            if (frame_cnt_q[gidx_q] != '1) frame_cnt_d[gidx_q] = frame_cnt_q[gidx_q] + CNT_W'(1);
            if (trunc_cnt_q != '1) trunc_cnt_d = trunc_cnt_q + CNT_W'(1);
            state_d = ST_DROP;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
`endif
        end
      end

`ifdef SW_ARB_OVERSIZE_TRUNC_EN
      ST_DROP: begin
        s_tready = grant_oh_q;
        if (sel_valid && sel_last) begin
          rr_ptr_d   = next_port(gidx_q);
          grant_oh_d = '0;
          state_d    = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      grant_oh_q  <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdest_q   <= '0;
      // NOTE: the counter array is architectural state visible on ports, so it is reset like any other flop.
      frame_cnt_q <= '{default: '0};
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
      beat_cnt_q  <= '0;
      m_tuser_q   <= 1'b0;
      trunc_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_oh_q  <= grant_oh_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tdest_q   <= m_tdest_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
      beat_cnt_q  <= beat_cnt_d;
      m_tuser_q   <= m_tuser_d;
      trunc_cnt_q <= trunc_cnt_d;
`endif
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdest  = m_tdest_q;
  assign grant_oh = grant_oh_q;

  for (genvar p = 0; p < PORTS; p++) begin : g_cnt_out
    assign frame_cnt[p*CNT_W +: CNT_W] = frame_cnt_q[p];
  end

`ifdef SW_ARB_OVERSIZE_TRUNC_EN
  assign m_tuser   = m_tuser_q;
  assign trunc_cnt = trunc_cnt_q;
`else
  assign m_tuser   = 1'b0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_sw_frame_arb_mux.sv
// Directed bench for sw_frame_arb_mux: queued per-port sources, captured egress beats, hand-built expectations.
// Build with SW_ARB_OVERSIZE_TRUNC_EN defined to exercise the truncation path (MAX_BEATS = 4 here).
module tb_sw_frame_arb_mux;

  localparam int PORTS     = 4;
  localparam int DATA_W    = 64;
  localparam int KEEP_W    = DATA_W / 8;
  localparam int DEST_W    = 2;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [DEST_W-1:0] dest;
    logic              user;
  } obeat_t;

  logic                    SysClk = 1'b0;
  logic                    Rst;
  logic [PORTS*DATA_W-1:0] s_tdata;
  logic [PORTS*KEEP_W-1:0] s_tkeep;
  logic [PORTS-1:0]        s_tvalid;
  logic [PORTS-1:0]        s_tlast;
  logic [PORTS-1:0]        s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic [KEEP_W-1:0]       m_tkeep;
  logic                    m_tvalid;
  logic                    m_tlast;
  logic [DEST_W-1:0]       m_tdest;
  logic                    m_tuser;
  logic                    m_tready;
  logic [PORTS*CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]        trunc_cnt;
  logic [PORTS-1:0]        grant_oh;

  beat_t            src_q [PORTS][$];
  logic [PORTS-1:0] hold = '0;
  obeat_t           out_q [$];
  obeat_t           exp_q [$];
  int               vectors = 0;
  int               miscompares = 0;

  sw_frame_arb_mux #(
    .PORTS(PORTS), .DATA_W(DATA_W), .DEST_W(DEST_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .SysClk(SysClk), .Rst(Rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .m_tuser(m_tuser), .m_tready(m_tready),
    .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt), .grant_oh(grant_oh)
  );

  always #5 SysClk = ~SysClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] mk(input int p, input int f, input int b);
    return {16'hDA7A, 8'(p), 8'(f), 32'(b)};
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(input bit last);
    return last ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic [CNT_W-1:0] fc(input int p);
    return frame_cnt[p*CNT_W +: CNT_W];
  endfunction

  task automatic add_frame(input int p, input int f, input int n);
    for (int b = 0; b < n; b++) src_q[p].push_back(beat_t'{mk(p, f, b), mk_keep(b == n - 1), b == n - 1});
  endtask

  task automatic expect_frame(input int p, input int f, input int n);
    for (int b = 0; b < n; b++)
      exp_q.push_back(obeat_t'{mk(p, f, b), mk_keep(b == n - 1), b == n - 1, DEST_W'(p), 1'b0});
  endtask

  task automatic drive();
    for (int p = 0; p < PORTS; p++) begin
      if (src_q[p].size() > 0 && !hold[p]) begin
        s_tvalid[p]                     = 1'b1;
        s_tdata[p*DATA_W +: DATA_W]     = src_q[p][0].data;
        s_tkeep[p*KEEP_W +: KEEP_W]     = src_q[p][0].keep;
        s_tlast[p]                      = src_q[p][0].last;
      end else begin
        s_tvalid[p]                     = 1'b0;
        s_tdata[p*DATA_W +: DATA_W]     = '0;
        s_tkeep[p*KEEP_W +: KEEP_W]     = '0;
        s_tlast[p]                      = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes mid-cycle, advance sources after the edge, re-drive.
  task automatic step();
    logic [PORTS-1:0] acc;
    @(negedge SysClk);
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready) out_q.push_back(obeat_t'{m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser});
    @(posedge SysClk);
    #1;
    for (int p = 0; p < PORTS; p++) if (acc[p]) void'(src_q[p].pop_front());
    drive();
  endtask

  function automatic bit busy();
    for (int p = 0; p < PORTS; p++) if (src_q[p].size() > 0) return 1'b1;
    return m_tvalid;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (busy()) begin
      miscompares++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, budget);
    end
  endtask

  task automatic do_reset();
    Rst      = 1'b1;
    m_tready = 1'b1;
    hold     = '0;
    for (int p = 0; p < PORTS; p++) src_q[p].delete();
    drive();
    repeat (2) @(posedge SysClk);
    #1;
    Rst = 1'b0;
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    vectors++; if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin miscompares++; $display("FAIL rst_last_user: got %b%b want 00", m_tlast, m_tuser); end
    vectors++; if (m_tdest !== '0) begin miscompares++; $display("FAIL rst_tdest: got %0d want 0", m_tdest); end
    vectors++; if (grant_oh !== '0) begin miscompares++; $display("FAIL rst_grant: got %b want 0000", grant_oh); end
    vectors++; if (s_tready !== '0) begin miscompares++; $display("FAIL rst_tready: got %b want 0000", s_tready); end
    vectors++; if (frame_cnt !== '0) begin miscompares++; $display("FAIL rst_frame_cnt: got %h want 0", frame_cnt); end
    vectors++; if (trunc_cnt !== '0) begin miscompares++; $display("FAIL rst_trunc_cnt: got %0d want 0", trunc_cnt); end
  endtask

  task automatic test_single_frame();
    add_frame(2, 0, 3);
    drive();
    step();
    vectors++; if (grant_oh !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b want 0100", grant_oh); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL single_t1_valid: got %b want 0", m_tvalid); end
    vectors++; if (s_tready !== 4'b0100) begin miscompares++; $display("FAIL single_tready: got %b want 0100", s_tready); end
    step();
    vectors++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hDA7A_0200_0000_0000 || m_tlast !== 1'b0 || m_tdest !== 2'd2)
      begin miscompares++; $display("FAIL single_beat0: got v%b %h l%b d%0d want v1 da7a020000000000 l0 d2", m_tvalid, m_tdata, m_tlast, m_tdest); end
    step();
    vectors++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hDA7A_0200_0000_0001 || m_tlast !== 1'b0)
      begin miscompares++; $display("FAIL single_beat1: got v%b %h l%b want v1 da7a020000000001 l0", m_tvalid, m_tdata, m_tlast); end
    step();
    vectors++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hDA7A_0200_0000_0002 || m_tlast !== 1'b1 || m_tkeep !== 8'h0F || m_tuser !== 1'b0)
      begin miscompares++; $display("FAIL single_beat2: got v%b %h k%h l%b u%b want v1 da7a020000000002 k0f l1 u0", m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser); end
    vectors++; if (fc(2) !== 32'd1) begin miscompares++; $display("FAIL single_frame_cnt2: got %0d want 1", fc(2)); end
    vectors++; if (grant_oh !== '0) begin miscompares++; $display("FAIL single_grant_idle: got %b want 0000", grant_oh); end
    drain("single", 20);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < PORTS; p++) begin
        add_frame(p, f, 2);
        expect_frame(p, f, 2);
      end
    drive();
    drain("rr", 200);
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rr_count: got %0d beats want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rr_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    for (int p = 0; p < PORTS; p++) begin
      vectors++; if (fc(p) !== 32'd2) begin miscompares++; $display("FAIL rr_frame_cnt%0d: got %0d want 2", p, fc(p)); end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    out_q.delete();
    exp_q.delete();
    add_frame(1, 0, 6);
    expect_frame(1, 0, 6);
    drive();
    repeat (3) step();
    m_tready = 1'b0;
    held     = m_tdata;
    vectors++; if (held !== 64'hDA7A_0100_0000_0001) begin miscompares++; $display("FAIL bp_held_beat: got %h want da7a010000000001", held); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (m_tvalid !== 1'b1 || m_tdata !== held || s_tready !== '0)
        begin miscompares++; $display("FAIL bp_stall%0d: got v%b %h r%b want v1 %h r0000", i, m_tvalid, m_tdata, s_tready, held); end
    end
    m_tready = 1'b1;
    drain("bp", 40);
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d beats want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (fc(1) !== 32'd3) begin miscompares++; $display("FAIL bp_frame_cnt1: got %0d want 3", fc(1)); end
  endtask

  task automatic test_upstream_stall();
    out_q.delete();
    exp_q.delete();
    add_frame(1, 1, 4);
    expect_frame(1, 1, 4);
    drive();
    step();
    vectors++; if (grant_oh !== 4'b0010) begin miscompares++; $display("FAIL stall_grant: got %b want 0010", grant_oh); end
    step();
    hold[1] = 1'b1;
    add_frame(0, 2, 2);
    expect_frame(0, 2, 2);
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (grant_oh !== 4'b0010 || s_tready[0] !== 1'b0)
        begin miscompares++; $display("FAIL stall_hold%0d: got grant %b ready0 %b want 0010 0", i, grant_oh, s_tready[0]); end
    end
    hold[1] = 1'b0;
    drive();
    drain("stall", 40);
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL stall_count: got %0d beats want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (fc(0) !== 32'd3) begin miscompares++; $display("FAIL stall_frame_cnt0: got %0d want 3", fc(0)); end
  endtask

  task automatic test_oversize();
    logic [CNT_W-1:0] trunc_exp;
    out_q.delete();
    exp_q.delete();
    add_frame(3, 3, 7);
    add_frame(3, 4, 4);
`ifdef SW_ARB_OVERSIZE_TRUNC_EN
    for (int b = 0; b < 4; b++)
      exp_q.push_back(obeat_t'{mk(3, 3, b), 8'hFF, b == 3, 2'd3, b == 3});
    trunc_exp = 32'd1;
`else
    expect_frame(3, 3, 7);
    trunc_exp = 32'd0;
`endif
    expect_frame(3, 4, 4);
    drive();
    drain("oversize", 60);
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL oversize_count: got %0d beats want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL oversize_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (trunc_cnt !== trunc_exp) begin miscompares++; $display("FAIL oversize_trunc_cnt: got %0d want %0d", trunc_cnt, trunc_exp); end
    vectors++; if (fc(3) !== 32'd4) begin miscompares++; $display("FAIL oversize_frame_cnt3: got %0d want 4", fc(3)); end
  endtask

  task automatic test_reset_midframe();
    add_frame(2, 5, 5);
    drive();
    repeat (4) step();
    vectors++; if (m_tvalid !== 1'b1 || grant_oh !== 4'b0100)
      begin miscompares++; $display("FAIL rstmid_pre: got v%b grant %b want v1 0100", m_tvalid, grant_oh); end
    Rst = 1'b1;
    for (int p = 0; p < PORTS; p++) src_q[p].delete();
    drive();
    @(posedge SysClk);
    #1;
    vectors++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0 || m_tdest !== '0)
      begin miscompares++; $display("FAIL rstmid_out: got v%b %h l%b d%0d want v0 0 l0 d0", m_tvalid, m_tdata, m_tlast, m_tdest); end
    vectors++; if (grant_oh !== '0 || s_tready !== '0)
      begin miscompares++; $display("FAIL rstmid_idle: got grant %b ready %b want 0000 0000", grant_oh, s_tready); end
    vectors++; if (frame_cnt !== '0 || trunc_cnt !== '0)
      begin miscompares++; $display("FAIL rstmid_cnt: got %h %0d want 0 0", frame_cnt, trunc_cnt); end
    Rst = 1'b0;
    out_q.delete();
    exp_q.delete();
    add_frame(3, 6, 1);
    add_frame(0, 6, 1);
    expect_frame(0, 6, 1);
    expect_frame(3, 6, 1);
    drive();
    step();
    vectors++; if (grant_oh !== 4'b0001) begin miscompares++; $display("FAIL rstmid_first_grant: got %b want 0001", grant_oh); end
    drain("rstmid", 20);
    vectors++; if (out_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d beats want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_upstream_stall();
    test_oversize();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
